turn_shot_ctrl: RTL and testbench
=================================

Name: turn_shot_ctrl

Overview:
- Turn controller for the battleship game.
- Alternates two players and gives one player at a time access to the shared shot bus into the ship registers.
- Validates each shot, rejects repeated cells, and passes the hit/sunk result back to the shooting player.
- Enforces a per-turn timeout and declares the winner once all of a board's ships are sunk.

Parameters:
- NUM_SHIPS, 5, ships per board; width of the alive vectors.
- BOARD_CELLS, 25, legal cells are 1..BOARD_CELLS; 0 means a cleared/empty slot.
- TURN_TIMEOUT, 1000, cycles a player may idle in a turn before the turn is forfeited.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a game from IDLE or GAME_OVER
- p1_fire  in  1  player 1 shot request
- p1_cell  in  5  player 1 target cell
- p2_fire  in  1  player 2 shot request
- p2_cell  in  5  player 2 target cell
- shot_valid  out  1  shot presented to the ship registers
- shot_cell  out  5  cell being fired at
- shot_board  out  1  board under attack: 0 = player 2 board, 1 = player 1 board
- res_valid  in  1  ship registers report the result of the shot
- res_hit  in  1  the shot cell matched a ship cell
- alive1  in  NUM_SHIPS  player 1 ships still afloat, one bit per ship
- alive2  in  NUM_SHIPS  player 2 ships still afloat, one bit per ship
- turn  out  1  current shooter: 0 = P1, 1 = P2
- fire_ack  out  1  one-cycle pulse: shot accepted
- fire_err  out  1  one-cycle pulse: shot rejected
- last_hit  out  1  result of the last completed shot
- timeout  out  1  one-cycle pulse: turn forfeited
- game_over  out  1  game finished
- winner  out  2  00 none, 01 P1, 10 P2

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; every output 0.
  - Both shot-history bitmaps and the timeout counter cleared.
- States: IDLE, TURN, WAIT, GAME_OVER.
- IDLE -> TURN on start.
  - turn=0; histories and counter cleared.
- TURN:
  - Only the current player's fire/cell is sampled; the other player's fire is ignored (no ack, no err).
  - Rejection: cell==0, cell>BOARD_CELLS, or cell already set in the shooter's history.
    - fire_err pulses the next cycle; stay in TURN.
    - The counter keeps running.
  - Acceptance:
    - Next cycle: fire_ack pulses, shot_valid=1, shot_cell=cell, shot_board=turn.
    - The shooter's history bit is set; go to WAIT; counter cleared.
  - Counter increments each TURN cycle without acceptance.
    - When it reaches TURN_TIMEOUT-1: timeout pulses, turn toggles, counter clears.
  - If fire is accepted in the same cycle the counter expires, fire wins; no timeout.
- WAIT:
  - shot_valid, shot_cell and shot_board are held stable until res_valid.
  - On res_valid:
    - shot_valid drops; last_hit<=res_hit.
    - Defender alive vector = alive2 if turn==0, else alive1.
  - Defender alive vector all zero (sampled on the res_valid cycle): go to GAME_OVER.
    - game_over=1; winner = 01 if turn==0, else 10.
  - Otherwise: turn toggles; go to TURN.
  - Player fire requests are ignored during WAIT.
- GAME_OVER:
  - Outputs hold.
  - start re-enters TURN with histories cleared, game_over=0, winner=00, last_hit=0.
- start in TURN or WAIT: ignored.
- Reset mid-WAIT aborts the shot; shot_valid falls immediately.
- History: two BOARD_CELLS-bit vectors; bit (cell-1) marks a cell already fired at.
- Counter width: $clog2(TURN_TIMEOUT).

Optional Feature:
- Macro: EXTRA_TURN_ON_HIT_EN.
- Defined: on a res_hit=1 that does not end the game, turn does not toggle; the same player shoots again.
  - The counter restarts for that extra turn.
- Undefined: turn always toggles after a result; res_hit only updates last_hit.

Test Plan:
- Reset, then start; P1 fires cell 7; res_valid with res_hit=1 and alive2=5'b11111 -> fire_ack one cycle later, shot_cell=7, shot_board=0, last_hit=1, turn=1.
- P2 fires cell 0, then cell 26 -> fire_err pulses twice, no shot_valid, turn stays 1.
- P1 fires cell 7 on its second turn -> fire_err (repeat shot); the cell 7 shot from P2 is still accepted.
- P1 idles TURN_TIMEOUT=16 cycles -> timeout pulses on cycle 16, turn=1; no shot issued.
- Final P1 shot with res_valid and alive2=0 -> game_over=1, winner=01; further fires ignored; start returns to TURN, winner=00.
- rst low during WAIT -> all outputs 0 asynchronously; with EXTRA_TURN_ON_HIT_EN defined, a hit keeps turn=0.

Source files
------------

// File: rtl/turn_shot_ctrl.sv
// Battleship turn controller: alternates players on the shared shot bus, rejects
// illegal or repeated shots, forfeits idle turns and declares the winner.
// Optional feature macro: EXTRA_TURN_ON_HIT_EN (a non-final hit grants another shot).
module turn_shot_ctrl #(
    parameter int NUM_SHIPS    = 5,
    parameter int BOARD_CELLS  = 25,
    parameter int TURN_TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 p1_fire,
    input  logic [4:0]           p1_cell,
    input  logic                 p2_fire,
    input  logic [4:0]           p2_cell,
    output logic                 shot_valid,
    output logic [4:0]           shot_cell,
    output logic                 shot_board,
    input  logic                 res_valid,
    input  logic                 res_hit,
    input  logic [NUM_SHIPS-1:0] alive1,
    input  logic [NUM_SHIPS-1:0] alive2,
    output logic                 turn,
    output logic                 fire_ack,
    output logic                 fire_err,
    output logic                 last_hit,
    output logic                 timeout,
    output logic                 game_over,
    output logic [1:0]           winner
);

    localparam int CNT_W = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TURN_TIMEOUT - 1);
    localparam logic [4:0] CELL_MAX = 5'(BOARD_CELLS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TURN = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    logic [1:0]             state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [BOARD_CELLS-1:0] hist1_r;
    logic [BOARD_CELLS-1:0] hist2_r;

    logic                   sel_fire_s;
    logic [4:0]             sel_cell_s;
    logic [BOARD_CELLS-1:0] shooter_hist_s;
    logic [BOARD_CELLS-1:0] cell_onehot_s;
    logic                   accept_s;
    logic                   reject_s;
    logic                   expire_s;
    logic [NUM_SHIPS-1:0]   defender_s;
    logic                   defender_sunk_s;
    logic                   keep_turn_s;

    function automatic logic cell_in_range(input logic [4:0] c);
        return (c != 5'd0) && (c <= CELL_MAX);
    endfunction

    // Shot decode for the current shooter plus timeout and defender status.
    always_comb begin
        sel_fire_s     = turn ? p2_fire : p1_fire;
        sel_cell_s     = turn ? p2_cell : p1_cell;
        shooter_hist_s = turn ? hist2_r : hist1_r;
        defender_s     = turn ? alive1  : alive2;
        if (cell_in_range(sel_cell_s)) begin
            cell_onehot_s = {{(BOARD_CELLS-1){1'b0}}, 1'b1} << (sel_cell_s - 5'd1);
        end else begin
            cell_onehot_s = {BOARD_CELLS{1'b0}};
        end
        accept_s = (state_r == ST_TURN) && sel_fire_s && cell_in_range(sel_cell_s) &&
                   ((shooter_hist_s & cell_onehot_s) == {BOARD_CELLS{1'b0}});
        reject_s = (state_r == ST_TURN) && sel_fire_s && !accept_s;
        // An accepted shot in the expiry cycle pre-empts the forfeit.
        expire_s = (state_r == ST_TURN) && !accept_s && (cnt_r == CNT_LAST);
        defender_sunk_s = (defender_s == {NUM_SHIPS{1'b0}});
`ifdef EXTRA_TURN_ON_HIT_EN
        keep_turn_s = res_hit;
`else
        keep_turn_s = 1'b0;
`endif
    end

    // Turn FSM with registered outputs, shot histories and idle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            hist1_r    <= {BOARD_CELLS{1'b0}};
            hist2_r    <= {BOARD_CELLS{1'b0}};
            shot_valid <= 1'b0;
            shot_cell  <= 5'd0;
            shot_board <= 1'b0;
            turn       <= 1'b0;
            fire_ack   <= 1'b0;
            fire_err   <= 1'b0;
            last_hit   <= 1'b0;
            timeout    <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
        end else begin
            fire_ack <= 1'b0;
            fire_err <= 1'b0;
            timeout  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_TURN;
                        turn    <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                        hist1_r <= {BOARD_CELLS{1'b0}};
                        hist2_r <= {BOARD_CELLS{1'b0}};
                    end
                end
                ST_TURN: begin
                    if (accept_s) begin
                        state_r    <= ST_WAIT;
                        fire_ack   <= 1'b1;
                        shot_valid <= 1'b1;
                        shot_cell  <= sel_cell_s;
                        shot_board <= turn;
                        cnt_r      <= {CNT_W{1'b0}};
                        if (turn) begin
                            hist2_r <= hist2_r | cell_onehot_s;
                        end else begin
                            hist1_r <= hist1_r | cell_onehot_s;
                        end
                    end else begin
                        fire_err <= reject_s;
                        if (expire_s) begin
                            timeout <= 1'b1;
                            turn    <= ~turn;
                            cnt_r   <= {CNT_W{1'b0}};
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (res_valid) begin
                        shot_valid <= 1'b0;
                        last_hit   <= res_hit;
                        if (defender_sunk_s) begin
                            state_r   <= ST_OVER;
                            game_over <= 1'b1;
                            winner    <= turn ? 2'b10 : 2'b01;
                        end else begin
                            state_r <= ST_TURN;
                            cnt_r   <= {CNT_W{1'b0}};
                            if (!keep_turn_s) begin
                                turn <= ~turn;
                            end
                        end
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        state_r   <= ST_TURN;
                        turn      <= 1'b0;
                        cnt_r     <= {CNT_W{1'b0}};
                        hist1_r   <= {BOARD_CELLS{1'b0}};
                        hist2_r   <= {BOARD_CELLS{1'b0}};
                        game_over <= 1'b0;
                        winner    <= 2'b00;
                        last_hit  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turn_shot_ctrl.sv
// Self-checking bench for turn_shot_ctrl: directed game scenario followed by
// randomized play, compared every cycle against a game-level reference model.
module tb_turn_shot_ctrl;

    localparam int NS = 5;
    localparam int BC = 25;
    localparam int TO = 16;
    localparam int P_IDLE = 0, P_TURN = 1, P_WAIT = 2, P_OVER = 3;
    localparam bit FIRST_HIT =
`ifdef EXTRA_TURN_ON_HIT_EN
        1'b0;
`else
        1'b1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start, p1_fire, p2_fire, res_valid, res_hit;
    logic [4:0] p1_cell, p2_cell;
    logic [NS-1:0] alive1, alive2;
    logic shot_valid, shot_board, turn, fire_ack, fire_err, last_hit, timeout, game_over;
    logic [4:0] shot_cell;
    logic [1:0] winner;

    int n_checks = 0;
    int n_pass = 0;

    // Reference game state.
    int m_phase, m_idle, m_scell, m_win;
    bit m_turn, m_sv, m_sboard, m_ack, m_err, m_lh, m_to, m_go;
    bit m_fired[2][32];

    turn_shot_ctrl #(.NUM_SHIPS(NS), .BOARD_CELLS(BC), .TURN_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .p1_fire(p1_fire), .p1_cell(p1_cell), .p2_fire(p2_fire), .p2_cell(p2_cell),
        .shot_valid(shot_valid), .shot_cell(shot_cell), .shot_board(shot_board),
        .res_valid(res_valid), .res_hit(res_hit), .alive1(alive1), .alive2(alive2),
        .turn(turn), .fire_ack(fire_ack), .fire_err(fire_err), .last_hit(last_hit),
        .timeout(timeout), .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    task automatic clear_fired();
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 32; c++) m_fired[p][c] = 1'b0;
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_idle = 0; m_scell = 0; m_win = 0;
        m_turn = 0; m_sv = 0; m_sboard = 0; m_ack = 0; m_err = 0;
        m_lh = 0; m_to = 0; m_go = 0;
        clear_fired();
    endtask

    task automatic model_step();
        bit f;
        int c;
        int dfd;
        bit accepted;
        m_ack = 0; m_err = 0; m_to = 0;
        accepted = 0;
        case (m_phase)
            P_IDLE: if (start) begin
                m_phase = P_TURN; m_turn = 0; m_idle = 0; clear_fired();
            end
            P_TURN: begin
                f = m_turn ? p2_fire : p1_fire;
                c = m_turn ? int'(p2_cell) : int'(p1_cell);
                if (f) begin
                    if (c >= 1 && c <= BC && !m_fired[m_turn][c]) begin
                        accepted = 1;
                        m_ack = 1; m_sv = 1; m_scell = c; m_sboard = m_turn;
                        m_fired[m_turn][c] = 1; m_phase = P_WAIT; m_idle = 0;
                    end else begin
                        m_err = 1;
                    end
                end
                if (!accepted) begin
                    if (m_idle == TO - 1) begin
                        m_to = 1; m_turn = !m_turn; m_idle = 0;
                    end else begin
                        m_idle++;
                    end
                end
            end
            P_WAIT: if (res_valid) begin
                m_sv = 0; m_lh = res_hit;
                dfd = m_turn ? int'(alive1) : int'(alive2);
                if (dfd == 0) begin
                    m_phase = P_OVER; m_go = 1; m_win = m_turn ? 2 : 1;
                end else begin
                    m_phase = P_TURN; m_idle = 0;
`ifdef EXTRA_TURN_ON_HIT_EN
                    if (!res_hit) m_turn = !m_turn;
`else
                    m_turn = !m_turn;
`endif
                end
            end
            default: if (start) begin
                m_phase = P_TURN; m_turn = 0; m_idle = 0; clear_fired();
                m_go = 0; m_win = 0; m_lh = 0;
            end
        endcase
    endtask

    task automatic check_all();
        chk("shot_valid", shot_valid, m_sv);
        chk("shot_cell", shot_cell, m_scell);
        chk("shot_board", shot_board, m_sboard);
        chk("turn", turn, m_turn);
        chk("fire_ack", fire_ack, m_ack);
        chk("fire_err", fire_err, m_err);
        chk("last_hit", last_hit, m_lh);
        chk("timeout", timeout, m_to);
        chk("game_over", game_over, m_go);
        chk("winner", winner, m_win);
    endtask

    task automatic tick(input bit st, input bit f1, input int c1, input bit f2, input int c2,
                        input bit rv, input bit rh, input logic [4:0] a1, input logic [4:0] a2);
        start = st; p1_fire = f1; p1_cell = c1[4:0]; p2_fire = f2; p2_cell = c2[4:0];
        res_valid = rv; res_hit = rh; alive1 = a1; alive2 = a2;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_tick();
        tick(0, 0, 0, 0, 0, 0, 0, 5'h1f, 5'h1f);
    endtask

    initial begin
        rst = 1'b0;
        start = 0; p1_fire = 0; p2_fire = 0; p1_cell = 0; p2_cell = 0;
        res_valid = 0; res_hit = 0; alive1 = 5'h1f; alive2 = 5'h1f;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b1;
        idle_tick();

        // Game start, first P1 shot at cell 7 and its hit result.
        tick(1, 0, 0, 0, 0, 0, 0, 5'h1f, 5'h1f);
        tick(0, 1, 7, 0, 0, 0, 0, 5'h1f, 5'h1f);
        chk("d_ack", fire_ack, 1); chk("d_cell", shot_cell, 7); chk("d_board", shot_board, 0);
        idle_tick();
        chk("d_hold_valid", shot_valid, 1);
        tick(0, 1, 8, 0, 0, 1, FIRST_HIT, 5'h1f, 5'h1f);
        chk("d_last_hit", last_hit, FIRST_HIT); chk("d_turn1", turn, 1);

        // P2 illegal cells, and a P1 fire out of turn.
        tick(0, 0, 0, 1, 0, 0, 0, 5'h1f, 5'h1f);
        chk("d_err0", fire_err, 1);
        tick(0, 0, 0, 1, 26, 0, 0, 5'h1f, 5'h1f);
        chk("d_err26", fire_err, 1); chk("d_no_shot", shot_valid, 0); chk("d_turn_stay", turn, 1);
        tick(0, 1, 5, 0, 0, 0, 0, 5'h1f, 5'h1f);
        chk("d_other_ignored", fire_ack | fire_err, 0);

        // P2 may fire at cell 7 (separate history); miss returns turn to P1.
        tick(0, 0, 0, 1, 7, 0, 0, 5'h1f, 5'h1f);
        chk("d_p2_ack", fire_ack, 1); chk("d_p2_board", shot_board, 1);
        tick(0, 0, 0, 0, 0, 1, 0, 5'h1f, 5'h1f);
        chk("d_turn0", turn, 0);

        // P1 idles: forfeit on the 16th TURN cycle.
        repeat (TO - 1) idle_tick();
        chk("d_to_early", timeout, 0);
        idle_tick();
        chk("d_to_pulse", timeout, 1); chk("d_to_turn", turn, 1); chk("d_to_noshot", shot_valid, 0);

        tick(0, 0, 0, 1, 9, 0, 0, 5'h1f, 5'h1f);
        tick(0, 0, 0, 0, 0, 1, 0, 5'h1f, 5'h1f);
        tick(0, 1, 7, 0, 0, 0, 0, 5'h1f, 5'h1f);
        chk("d_repeat_err", fire_err, 1);

        // Final shot sinks P2's fleet.
        tick(0, 1, 12, 0, 0, 0, 0, 5'h1f, 5'h1f);
        tick(0, 0, 0, 0, 0, 1, 1, 5'h1f, 5'h00);
        chk("d_go", game_over, 1); chk("d_winner", winner, 2'b01);
        tick(0, 1, 13, 1, 14, 0, 0, 5'h1f, 5'h00);
        chk("d_over_ignored", fire_ack | fire_err | shot_valid, 0);
        tick(1, 0, 0, 0, 0, 0, 0, 5'h1f, 5'h1f);
        chk("d_restart_go", game_over, 0); chk("d_restart_win", winner, 0);

`ifdef EXTRA_TURN_ON_HIT_EN
        tick(0, 1, 3, 0, 0, 0, 0, 5'h1f, 5'h1f);
        tick(0, 0, 0, 0, 0, 1, 1, 5'h1f, 5'h1f);
        chk("d_extra_turn", turn, 0);
`endif

        // Asynchronous reset while a shot is outstanding.
        tick(0, 1, 4, 0, 0, 0, 0, 5'h1f, 5'h1f);
        chk("d_wait_valid", shot_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("d_rst_valid", shot_valid, 0);
        chk("d_rst_outs", {shot_cell, shot_board, turn, fire_ack, last_hit, winner}, 0);
        model_reset();
        @(negedge clk);
        check_all();
        rst = 1'b1;
        idle_tick();
        tick(1, 0, 0, 0, 0, 0, 0, 5'h1f, 5'h1f);

        // Randomized play.
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 39) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 31),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 31),
                 $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0) ? 5'h00 : 5'($urandom_range(1, 31)),
                 ($urandom_range(0, 15) == 0) ? 5'h00 : 5'($urandom_range(1, 31)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
